// File: rtl/bus_controller_if.sv
// Request/completion handshake between a requester and the bus controller.
// The requester holds cmd_* until cmd_ready; done_* and ack are single-cycle pulses.
interface bus_controller_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_src;
    logic [1:0] cmd_dst;
    logic [1:0] cmd_op;
    logic [7:0] cmd_len;
    logic       ack;
    logic       done_valid;
    logic       done_err;
    logic [7:0] done_count;
    logic       busy;

    modport master (
        output cmd_valid, cmd_src, cmd_dst, cmd_op, cmd_len,
        input  cmd_ready, ack, done_valid, done_err, done_count, busy
    );

    modport slave (
        input  cmd_valid, cmd_src, cmd_dst, cmd_op, cmd_len,
        output cmd_ready, ack, done_valid, done_err, done_count, busy
    );
endinterface

// File: rtl/bus_controller.sv
// Shared-bus sequencer: drives a 1-cycle header, releases the bus, counts payload bytes, then acks.
// Header-to-ack latency 1+GAP+len; cmd_ready only in IDLE, so new requests stall while a transfer runs.
module bus_controller #(
    parameter int TIMEOUT = 255,
    parameter int GAP     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    bus_controller_if.slave  cif,
    inout  wire  [7:0]       bus_data,
    inout  wire              bus_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_GAP,
        S_DATA,
        S_ACK
    } state_t;

    state_t     state;
    logic [1:0] src_q;
    logic [1:0] dst_q;
    logic [1:0] op_q;
    logic [7:0] len_q;
    logic [7:0] byte_cnt;
    logic [7:0] idle_cnt;
    logic [2:0] gap_cnt;
    logic       ack_q;
    logic       done_vld_q;
    logic       done_err_q;
    logic [7:0] done_cnt_q;

    logic cmd_fire;
    logic cmd_bad;
    logic byte_seen;

    assign cmd_fire  = cif.cmd_valid && (state == S_IDLE);
    assign cmd_bad   = (cif.cmd_src == 2'd3) || (cif.cmd_dst == 2'd3) ||
                       (cif.cmd_src == cif.cmd_dst);
    // Only a clean 1 is a byte; released (Z) or unknown bus cycles count as idle.
    assign byte_seen = (bus_valid === 1'b1);

    assign bus_valid = (state == S_HDR) ? 1'b1 : 1'bz;
    assign bus_data  = (state == S_HDR) ? {2'b00, dst_q, src_q, op_q} : 8'hzz;

    assign cif.cmd_ready  = (state == S_IDLE);
    assign cif.busy       = (state != S_IDLE);
    assign cif.ack        = ack_q;
    assign cif.done_valid = done_vld_q;
    assign cif.done_err   = done_err_q;
    assign cif.done_count = done_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            src_q      <= 2'd0;
            dst_q      <= 2'd0;
            op_q       <= 2'd0;
            len_q      <= 8'd0;
            byte_cnt   <= 8'd0;
            idle_cnt   <= 8'd0;
            gap_cnt    <= 3'd0;
            ack_q      <= 1'b0;
            done_vld_q <= 1'b0;
            done_err_q <= 1'b0;
            done_cnt_q <= 8'd0;
        end else begin
            ack_q      <= 1'b0;
            done_vld_q <= 1'b0;
            done_err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        if (cmd_bad) begin
                            done_vld_q <= 1'b1;
                            done_err_q <= 1'b1;
                            done_cnt_q <= 8'd0;
                        end else begin
                            src_q <= cif.cmd_src;
                            dst_q <= cif.cmd_dst;
                            op_q  <= cif.cmd_op;
                            len_q <= cif.cmd_len;
                            state <= S_HDR;
                        end
                    end
                end
                S_HDR: begin
                    gap_cnt  <= 3'(GAP - 1);
                    byte_cnt <= 8'd0;
                    idle_cnt <= 8'd0;
                    state    <= S_GAP;
                end
                S_GAP: begin
                    if (gap_cnt == 3'd0) begin
                        if (len_q == 8'd0) begin
                            ack_q      <= 1'b1;
                            done_vld_q <= 1'b1;
                            done_cnt_q <= 8'd0;
                            state      <= S_ACK;
                        end else begin
                            state <= S_DATA;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 3'd1;
                    end
                end
                S_DATA: begin
                    if (byte_seen) begin
                        byte_cnt <= byte_cnt + 8'd1;
                        idle_cnt <= 8'd0;
                        if (byte_cnt + 8'd1 == len_q) begin
                            ack_q      <= 1'b1;
                            done_vld_q <= 1'b1;
                            done_cnt_q <= byte_cnt + 8'd1;
                            state      <= S_ACK;
                        end
                    end else begin
                        idle_cnt <= idle_cnt + 8'd1;
                        // Timeout leaves DATA, so neither counter can run past its limit.
                        if (idle_cnt + 8'd1 == 8'(TIMEOUT)) begin
                            ack_q      <= 1'b1;
                            done_vld_q <= 1'b1;
                            done_err_q <= 1'b1;
                            done_cnt_q <= byte_cnt;
                            state      <= S_ACK;
                        end
                    end
                end
                S_ACK: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_controller.sv
// Randomised bench for bus_controller: a per-cycle expectation timeline is built from the
// transaction rules and compared against the DUT on every falling edge.
module tb_bus_controller;
    localparam int TO = 10;
    localparam int GP = 3;
    localparam int NC = 16384;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bus_controller_if cif();
    wire  [7:0] bus_data;
    wire        bus_valid;
    logic       node_drv = 1'b0;
    logic [7:0] node_d = 8'h00;

    assign bus_valid = node_drv ? 1'b1 : 1'bz;
    assign bus_data  = node_drv ? node_d : 8'hzz;

    bus_controller #(.TIMEOUT(TO), .GAP(GP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cif       (cif.slave),
        .bus_data  (bus_data),
        .bus_valid (bus_valid)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit       e_busy [NC];
    bit       e_ack  [NC];
    bit       e_dv   [NC];
    bit       e_de   [NC];
    bit [7:0] e_dc   [NC];
    bit       e_hdr  [NC];
    bit [7:0] e_hd   [NC];
    bit       pat    [512];

    int vectors = 0;
    int fails   = 0;
    int hdr_cyc, ack_cyc, dn_cyc;
    logic [7:0] hdr_val, dn_cnt;
    logic dn_err;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", n, cyc, got, exp);
        end
    endtask

    task automatic mon_clear();
        hdr_cyc = -1; ack_cyc = -1; dn_cyc = -1;
        hdr_val = 8'h00; dn_cnt = 8'h00; dn_err = 1'b0;
    endtask

    task automatic clear_exp(input int x);
        if (x < NC) begin
            e_busy[x] = 0; e_ack[x] = 0; e_dv[x] = 0; e_hdr[x] = 0;
        end
    endtask

    // Compare process plus a small monitor used by the hand-computed checks.
    always @(negedge clk) begin
        if (cyc < NC) begin
            chk("busy", cif.busy, e_busy[cyc]);
            chk("cmd_ready", cif.cmd_ready, !e_busy[cyc]);
            chk("ack", cif.ack, e_ack[cyc]);
            chk("done_valid", cif.done_valid, e_dv[cyc]);
            if (e_dv[cyc]) begin
                chk("done_err", cif.done_err, e_de[cyc]);
                chk("done_count", cif.done_count, e_dc[cyc]);
            end
            if (e_hdr[cyc]) begin
                chk("hdr_valid", bus_valid === 1'b1, 1'b1);
                chk("hdr_data", bus_data, e_hd[cyc]);
            end else if (!node_drv) begin
                chk("bus_released", bus_valid === 1'b1, 1'b0);
            end
            if (bus_valid === 1'b1 && !node_drv) begin
                hdr_cyc = cyc; hdr_val = bus_data;
            end
            if (cif.ack === 1'b1) ack_cyc = cyc;
            if (cif.done_valid === 1'b1) begin
                dn_cyc = cyc; dn_err = cif.done_err; dn_cnt = cif.done_count;
            end
        end
    end

    // Caller is 1 time unit past the rising edge that opens an IDLE cycle; returns likewise.
    task automatic run_txn(input logic [1:0] s, input logic [1:0] d, input logic [1:0] o,
                           input logic [7:0] len, input logic [2:0] gmask, input int rst_at);
        int k, h, d0, a, cnt, idl, t;
        bit err, b, aborted;
        k = cyc;
        aborted = 0;
        cif.cmd_valid = 1'b1;
        cif.cmd_src = s; cif.cmd_dst = d; cif.cmd_op = o; cif.cmd_len = len;
        if (s == 2'd3 || d == 2'd3 || s == d) begin
            e_dv[k+1] = 1; e_de[k+1] = 1; e_dc[k+1] = 8'd0;
            @(posedge clk); #1;
            cif.cmd_valid = 1'b0;
            @(posedge clk); #1;
        end else begin
            // Transfer timeline: header, GAP released cycles, then payload until len bytes or TO idles.
            h = k + 1; d0 = h + GP + 1; a = d0; cnt = 0; idl = 0; err = 0;
            if (len != 0) begin
                t = 0;
                while (t < 4000) begin
                    b = (t < 512) ? pat[t] : 1'b0;
                    if (b) begin cnt++; idl = 0; end else idl++;
                    if (cnt == int'(len)) begin a = d0 + t + 1; break; end
                    if (idl == TO) begin a = d0 + t + 1; err = 1; break; end
                    t++;
                end
            end
            for (int c = h; c <= a; c++) e_busy[c] = 1;
            e_hdr[h] = 1; e_hd[h] = {2'b00, d, s, o};
            e_ack[a] = 1; e_dv[a] = 1; e_de[a] = err; e_dc[a] = 8'(cnt);
            for (int c = k + 1; c <= a; c++) begin
                @(posedge clk); #1;
                cif.cmd_valid = 1'b0;
                node_d = 8'($urandom);
                if (rst_at >= 0 && c == h + rst_at) begin
                    for (int x = c; x <= a; x++) clear_exp(x);
                    rst_n = 1'b0; node_drv = 1'b0;
                    @(posedge clk); #1;
                    @(posedge clk); #1;
                    rst_n = 1'b1;
                    aborted = 1;
                    break;
                end
                if (c > h && c <= h + GP) node_drv = gmask[c-h-1];
                else if (c >= d0 && c < a) node_drv = pat[c-d0];
                else node_drv = 1'b0;
            end
            if (!aborted) begin
                @(posedge clk); #1;
                node_drv = 1'b0;
            end
        end
    endtask

    task automatic set_pat(input int nbytes);
        for (int i = 0; i < 512; i++) pat[i] = (i < nbytes);
    endtask

    initial begin
        int k0, n, len, s, d;
        cif.cmd_valid = 1'b0; cif.cmd_src = 2'd0; cif.cmd_dst = 2'd0;
        cif.cmd_op = 2'd0; cif.cmd_len = 8'd0;
        mon_clear();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Four back-to-back bytes.
        mon_clear(); set_pat(4);
        run_txn(2'd0, 2'd1, 2'd2, 8'd4, 3'b000, -1);
        chk("d1_header", hdr_val, 8'h12);
        chk("d1_latency", ack_cyc - hdr_cyc, 8);
        chk("d1_count", dn_cnt, 4);
        chk("d1_err", dn_err, 0);

        // Header-only transfer.
        mon_clear(); set_pat(0);
        run_txn(2'd2, 2'd0, 2'd0, 8'd0, 3'b000, -1);
        chk("d2_header", hdr_val, 8'h08);
        chk("d2_latency", ack_cyc - hdr_cyc, 4);
        chk("d2_count", dn_cnt, 0);

        // Rejected request: immediate error completion, no header or ack.
        mon_clear(); k0 = cyc;
        run_txn(2'd1, 2'd1, 2'd3, 8'd5, 3'b000, -1);
        chk("d3_done_lat", dn_cyc - k0, 1);
        chk("d3_err", dn_err, 1);
        chk("d3_no_ack", ack_cyc, -1);
        chk("d3_no_hdr", hdr_cyc, -1);

        // Two bytes then silence: timeout after TO idle cycles.
        mon_clear(); set_pat(2);
        run_txn(2'd0, 2'd2, 2'd1, 8'd5, 3'b000, -1);
        chk("d4_latency", ack_cyc - hdr_cyc, 16);
        chk("d4_err", dn_err, 1);
        chk("d4_count", dn_cnt, 2);

        // Valid pulses during the gap are ignored.
        mon_clear(); set_pat(3);
        run_txn(2'd1, 2'd2, 2'd3, 8'd3, 3'b101, -1);
        chk("d5_count", dn_cnt, 3);
        chk("d5_latency", ack_cyc - hdr_cyc, 7);
        chk("d5_err", dn_err, 0);

        // Reset in the middle of DATA, then a normal one-byte transfer.
        mon_clear(); set_pat(1);
        run_txn(2'd0, 2'd2, 2'd1, 8'd5, 3'b000, GP + 2);
        chk("d6_no_ack", ack_cyc, -1);
        chk("d6_no_done", dn_cyc, -1);
        mon_clear(); set_pat(1);
        run_txn(2'd2, 2'd1, 2'd0, 8'd1, 3'b000, -1);
        chk("d6_after_err", dn_err, 0);
        chk("d6_after_count", dn_cnt, 1);
        chk("d6_after_latency", ack_cyc - hdr_cyc, 5);

        n = 0;
        while (n < 150 && cyc < NC - 800) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            if ($urandom_range(0, 4) == 0) begin
                s = $urandom_range(0, 3); d = $urandom_range(0, 3);
            end else begin
                s = $urandom_range(0, 2); d = (s + $urandom_range(1, 2)) % 3;
            end
            len = $urandom_range(0, 12);
            for (int i = 0; i < 512; i++) pat[i] = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 5) == 0) begin
                k0 = $urandom_range(0, 8);
                for (int i = k0; i < 512; i++) pat[i] = 1'b0;
            end
            run_txn(2'(s), 2'(d), 2'($urandom), 8'(len), 3'($urandom),
                    ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, GP + len + 1)) : -1);
            n++;
        end

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
